// File: rtl/aurora_tx_arbiter_pkg.sv
// Shared types and constants for the Aurora TX arbiter and its round-robin picker.
// Defines the arbiter state encoding, the fixed lane data/keep widths and the drop counter width.
package aurora_tx_arb_pkg;

    localparam int DATA_W = 16;
    localparam int KEEP_W = DATA_W / 8;
    localparam int DROP_W = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SEND  = 2'd1,
        FLUSH = 2'd2
    } arb_state_t;

endpackage

// File: rtl/aurora_tx_arbiter_rr_pick.sv
// Combinational round-robin priority picker: returns the first asserted request
// strictly after i_last (with wrap), so the previous winner has lowest priority.
module rr_pick #(
    parameter int NUM_SRC = 4,
    parameter int IDX_W   = 2
) (
    input  logic [NUM_SRC-1:0] i_req,
    input  logic [IDX_W-1:0]   i_last,
    output logic [IDX_W-1:0]   o_idx,
    output logic               o_found
);

    // Scan from the farthest candidate to the nearest so the nearest one wins.
    always_comb begin
        logic [IDX_W-1:0] cand;
        cand    = '0;
        o_idx   = '0;
        o_found = 1'b0;
        for (int k = NUM_SRC; k >= 1; k--) begin
            cand = IDX_W'((int'(i_last) + k) % NUM_SRC);
            if (i_req[cand]) begin
                o_idx   = cand;
                o_found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/aurora_tx_arbiter.sv
// Frame-granular round-robin arbiter sharing one Aurora 16-bit AXI4-Stream TX port.
// Optional stall watchdog enabled by defining AURORA_TX_ARB_WDOG_EN (adds o_wdog_trip).
module aurora_tx_arbiter
    import aurora_tx_arb_pkg::*;
#(
    parameter int NUM_SRC = 4,
    parameter int IDX_W   = 2
) (
    input  logic                       i_user_clk,
    input  logic                       i_reset,
    input  logic                       i_channel_up,
    input  logic [NUM_SRC*DATA_W-1:0]  i_s_tdata,
    input  logic [NUM_SRC-1:0]         i_s_tvalid,
    input  logic [NUM_SRC*KEEP_W-1:0]  i_s_tkeep,
    input  logic [NUM_SRC-1:0]         i_s_tlast,
    output logic [NUM_SRC-1:0]         o_s_tready,
    output logic [DATA_W-1:0]          o_m_tdata,
    output logic                       o_m_tvalid,
    output logic [KEEP_W-1:0]          o_m_tkeep,
    output logic                       o_m_tlast,
    input  logic                       i_m_tready,
    output logic                       o_grant_valid,
    output logic [IDX_W-1:0]           o_grant_idx,
    output logic [DROP_W-1:0]          o_drop_cnt
`ifdef AURORA_TX_ARB_WDOG_EN
    ,
    output logic                       o_wdog_trip
`endif
);

    arb_state_t         r_state;
    arb_state_t         w_next_state;
    logic [IDX_W-1:0]   r_grant_idx;
    logic [IDX_W-1:0]   r_last_grant;
    logic [DROP_W-1:0]  r_drop_cnt;

    logic [IDX_W-1:0]   w_pick_idx;
    logic               w_pick_found;
    logic               w_grant_load;
    logic               w_last_load;
    logic               w_drop_inc;
    logic               w_sel_valid;
    logic               w_sel_last;

`ifdef AURORA_TX_ARB_WDOG_EN
    logic [15:0]        r_stall_cnt;
    logic               r_wdog_trip;
    logic               w_wdog_hit;
`endif

    rr_pick #(
        .NUM_SRC (NUM_SRC),
        .IDX_W   (IDX_W)
    ) u_rr_pick (
        .i_req   (i_s_tvalid),
        .i_last  (r_last_grant),
        .o_idx   (w_pick_idx),
        .o_found (w_pick_found)
    );

    // Zero-latency data path: the granted slice is steered straight to the core.
    assign w_sel_valid   = i_s_tvalid[r_grant_idx];
    assign w_sel_last    = i_s_tlast[r_grant_idx];
    assign o_m_tdata     = i_s_tdata[int'(r_grant_idx)*DATA_W +: DATA_W];
    assign o_m_tkeep     = i_s_tkeep[int'(r_grant_idx)*KEEP_W +: KEEP_W];
    assign o_m_tlast     = w_sel_last;
    assign o_grant_valid = (r_state != IDLE);
    assign o_grant_idx   = r_grant_idx;
    assign o_drop_cnt    = r_drop_cnt;

    always_comb begin
        w_next_state = r_state;
        o_m_tvalid   = 1'b0;
        o_s_tready   = '0;
        w_grant_load = 1'b0;
        w_last_load  = 1'b0;
        w_drop_inc   = 1'b0;
`ifdef AURORA_TX_ARB_WDOG_EN
        w_wdog_hit   = 1'b0;
`endif
        case (r_state)
            IDLE: begin
                if (i_channel_up && w_pick_found) begin
                    w_grant_load = 1'b1;
                    w_next_state = SEND;
                end
            end
            SEND: begin
                o_m_tvalid              = w_sel_valid;
                o_s_tready[r_grant_idx] = i_m_tready;
                // A completed tlast handshake wins over a coincident channel drop.
                if (w_sel_valid && i_m_tready && w_sel_last) begin
                    w_last_load  = 1'b1;
                    w_next_state = IDLE;
                end else if (!i_channel_up) begin
                    o_m_tvalid   = 1'b0;
                    w_next_state = FLUSH;
                end
`ifdef AURORA_TX_ARB_WDOG_EN
                else if (r_stall_cnt == 16'hFFFF) begin
                    o_m_tvalid   = 1'b0;
                    w_wdog_hit   = 1'b1;
                    w_next_state = FLUSH;
                end
`endif
            end
            FLUSH: begin
                o_s_tready[r_grant_idx] = 1'b1;
                if (w_sel_valid && w_sel_last) begin
                    w_drop_inc   = 1'b1;
                    w_last_load  = 1'b1;
                    w_next_state = IDLE;
                end
            end
            default: w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge i_user_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state      <= IDLE;
            r_grant_idx  <= '0;
            r_last_grant <= IDX_W'(NUM_SRC - 1);
            r_drop_cnt   <= '0;
        end else begin
            r_state <= w_next_state;
            if (w_grant_load) r_grant_idx <= w_pick_idx;
            if (w_last_load) r_last_grant <= r_grant_idx;
            if (w_drop_inc && (r_drop_cnt != {DROP_W{1'b1}})) r_drop_cnt <= r_drop_cnt + 1'b1;
        end
    end

`ifdef AURORA_TX_ARB_WDOG_EN
    // Stall counter only runs while granted; any handshake or leaving SEND clears it.
    always_ff @(posedge i_user_clk or posedge i_reset) begin
        if (i_reset) begin
            r_stall_cnt <= '0;
            r_wdog_trip <= 1'b0;
        end else begin
            r_wdog_trip <= w_wdog_hit;
            if ((r_state != SEND) || (o_m_tvalid && i_m_tready)) begin
                r_stall_cnt <= '0;
            end else if (!o_m_tvalid && (r_stall_cnt != 16'hFFFF)) begin
                r_stall_cnt <= r_stall_cnt + 16'd1;
            end
        end
    end

    assign o_wdog_trip = r_wdog_trip;
`endif

endmodule

// File: tb/tb_aurora_tx_arbiter.sv
// Self-checking bench for aurora_tx_arbiter: a directed vector table for arbitration
// and channel gating, plus hand-written sequences for flush, backpressure, bubbles and reset.
module tb_aurora_tx_arbiter;

    logic        clk;
    logic        i_reset;
    logic        i_channel_up;
    logic [63:0] i_s_tdata;
    logic [3:0]  i_s_tvalid;
    logic [7:0]  i_s_tkeep;
    logic [3:0]  i_s_tlast;
    logic [3:0]  o_s_tready;
    logic [15:0] o_m_tdata;
    logic        o_m_tvalid;
    logic [1:0]  o_m_tkeep;
    logic        o_m_tlast;
    logic        i_m_tready;
    logic        o_grant_valid;
    logic [1:0]  o_grant_idx;
    logic [15:0] o_drop_cnt;
`ifdef AURORA_TX_ARB_WDOG_EN
    logic        o_wdog_trip;
`endif

    int nChecks = 0;
    int nPassed = 0;
    int nHs     = 0;

    aurora_tx_arbiter #(
        .NUM_SRC (4),
        .IDX_W   (2)
    ) dut (
        .i_user_clk    (clk),
        .i_reset       (i_reset),
        .i_channel_up  (i_channel_up),
        .i_s_tdata     (i_s_tdata),
        .i_s_tvalid    (i_s_tvalid),
        .i_s_tkeep     (i_s_tkeep),
        .i_s_tlast     (i_s_tlast),
        .o_s_tready    (o_s_tready),
        .o_m_tdata     (o_m_tdata),
        .o_m_tvalid    (o_m_tvalid),
        .o_m_tkeep     (o_m_tkeep),
        .o_m_tlast     (o_m_tlast),
        .i_m_tready    (i_m_tready),
        .o_grant_valid (o_grant_valid),
        .o_grant_idx   (o_grant_idx),
        .o_drop_cnt    (o_drop_cnt)
`ifdef AURORA_TX_ARB_WDOG_EN
        ,
        .o_wdog_trip   (o_wdog_trip)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        cu;
        logic [3:0]  vld;
        logic [3:0]  lst;
        logic [15:0] base;
        logic        mrdy;
        logic        mv;
        logic [15:0] md;
        logic        ml;
        logic [3:0]  sr;
        logic        gv;
        logic [1:0]  gi;
    } vec_t;

    vec_t tbl[18];

    // Waits for the next rising edge, then drives one cycle of inputs; source i carries base+i.
    task automatic applyStimulus(input logic cu, input logic [3:0] vld, input logic [3:0] lst,
                                 input logic [15:0] base, input logic [1:0] keep, input logic mrdy);
        @(posedge clk);
        #1;
        i_channel_up = cu;
        i_s_tvalid   = vld;
        i_s_tlast    = lst;
        i_m_tready   = mrdy;
        for (int i = 0; i < 4; i++) begin
            i_s_tdata[i*16 +: 16] = base + 16'(i);
            i_s_tkeep[i*2 +: 2]   = keep;
        end
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act === exp) nPassed++;
        else $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic checkBeat(input string tag, input logic mv, input logic [15:0] md, input logic ml,
                             input logic [3:0] sr, input logic gv, input logic [1:0] gi);
        checkOutput({tag, ".m_tvalid"}, 32'(o_m_tvalid), 32'(mv));
        if (mv) begin
            checkOutput({tag, ".m_tdata"}, 32'(o_m_tdata), 32'(md));
            checkOutput({tag, ".m_tlast"}, 32'(o_m_tlast), 32'(ml));
        end
        checkOutput({tag, ".s_tready"}, 32'(o_s_tready), 32'(sr));
        checkOutput({tag, ".grant_valid"}, 32'(o_grant_valid), 32'(gv));
        checkOutput({tag, ".grant_idx"}, 32'(o_grant_idx), 32'(gi));
    endtask

    initial begin
        // Arbitration, round robin and channel gating: one row per clock cycle.
        tbl[0]  = '{1'b1, 4'b0000, 4'b0000, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b0, 4'b0000, 1'b0, 2'd0};
        tbl[1]  = '{1'b1, 4'b0001, 4'b0000, 16'hCAFE, 1'b1, 1'b0, 16'h0000, 1'b0, 4'b0000, 1'b0, 2'd0};
        tbl[2]  = '{1'b1, 4'b0001, 4'b0000, 16'hCAFE, 1'b1, 1'b1, 16'hCAFE, 1'b0, 4'b0001, 1'b1, 2'd0};
        tbl[3]  = '{1'b1, 4'b0001, 4'b0001, 16'hBABE, 1'b1, 1'b1, 16'hBABE, 1'b1, 4'b0001, 1'b1, 2'd0};
        tbl[4]  = '{1'b1, 4'b0000, 4'b0000, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b0, 4'b0000, 1'b0, 2'd0};
        tbl[5]  = '{1'b1, 4'b0111, 4'b0111, 16'hA000, 1'b1, 1'b0, 16'h0000, 1'b0, 4'b0000, 1'b0, 2'd0};
        tbl[6]  = '{1'b1, 4'b0111, 4'b0111, 16'hA000, 1'b1, 1'b1, 16'hA001, 1'b1, 4'b0010, 1'b1, 2'd1};
        tbl[7]  = '{1'b1, 4'b0111, 4'b0111, 16'hA000, 1'b1, 1'b0, 16'h0000, 1'b0, 4'b0000, 1'b0, 2'd1};
        tbl[8]  = '{1'b1, 4'b0111, 4'b0111, 16'hA000, 1'b1, 1'b1, 16'hA002, 1'b1, 4'b0100, 1'b1, 2'd2};
        tbl[9]  = '{1'b1, 4'b0111, 4'b0111, 16'hA000, 1'b1, 1'b0, 16'h0000, 1'b0, 4'b0000, 1'b0, 2'd2};
        tbl[10] = '{1'b1, 4'b0111, 4'b0111, 16'hA000, 1'b1, 1'b1, 16'hA000, 1'b1, 4'b0001, 1'b1, 2'd0};
        tbl[11] = '{1'b1, 4'b0111, 4'b0111, 16'hA000, 1'b1, 1'b0, 16'h0000, 1'b0, 4'b0000, 1'b0, 2'd0};
        tbl[12] = '{1'b1, 4'b0111, 4'b0111, 16'hA000, 1'b1, 1'b1, 16'hA001, 1'b1, 4'b0010, 1'b1, 2'd1};
        tbl[13] = '{1'b0, 4'b0010, 4'b0010, 16'hA000, 1'b1, 1'b0, 16'h0000, 1'b0, 4'b0000, 1'b0, 2'd1};
        tbl[14] = '{1'b0, 4'b0010, 4'b0010, 16'hA000, 1'b1, 1'b0, 16'h0000, 1'b0, 4'b0000, 1'b0, 2'd1};
        tbl[15] = '{1'b1, 4'b0010, 4'b0010, 16'hA000, 1'b1, 1'b0, 16'h0000, 1'b0, 4'b0000, 1'b0, 2'd1};
        tbl[16] = '{1'b1, 4'b0010, 4'b0010, 16'hA000, 1'b1, 1'b1, 16'hA001, 1'b1, 4'b0010, 1'b1, 2'd1};
        tbl[17] = '{1'b1, 4'b0000, 4'b0000, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b0, 4'b0000, 1'b0, 2'd1};

        i_reset      = 1'b1;
        i_channel_up = 1'b0;
        i_s_tdata    = '0;
        i_s_tvalid   = '0;
        i_s_tkeep    = '0;
        i_s_tlast    = '0;
        i_m_tready   = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checkBeat("reset", 1'b0, 16'h0, 1'b0, 4'b0000, 1'b0, 2'd0);
        checkOutput("reset.drop_cnt", 32'(o_drop_cnt), 32'd0);
        @(posedge clk);
        #1;
        i_reset = 1'b0;

        for (int v = 0; v < 18; v++) begin
            applyStimulus(tbl[v].cu, tbl[v].vld, tbl[v].lst, tbl[v].base, 2'b11, tbl[v].mrdy);
            checkBeat($sformatf("vec%0d", v), tbl[v].mv, tbl[v].md, tbl[v].ml, tbl[v].sr, tbl[v].gv, tbl[v].gi);
        end
        checkOutput("table.drop_cnt", 32'(o_drop_cnt), 32'd0);

        // Channel drops after beat 2 of a 5-beat frame from requester 3.
        applyStimulus(1'b1, 4'b1000, 4'b0000, 16'h1000, 2'b11, 1'b1);
        checkBeat("drop.idle", 1'b0, 16'h0, 1'b0, 4'b0000, 1'b0, 2'd1);
        applyStimulus(1'b1, 4'b1000, 4'b0000, 16'h1000, 2'b11, 1'b1);
        checkBeat("drop.b1", 1'b1, 16'h1003, 1'b0, 4'b1000, 1'b1, 2'd3);
        checkOutput("drop.b1.keep", 32'(o_m_tkeep), 32'h3);
        applyStimulus(1'b1, 4'b1000, 4'b0000, 16'h1100, 2'b11, 1'b1);
        checkBeat("drop.b2", 1'b1, 16'h1103, 1'b0, 4'b1000, 1'b1, 2'd3);
        applyStimulus(1'b0, 4'b1000, 4'b0000, 16'h1200, 2'b11, 1'b1);
        checkBeat("drop.b3", 1'b0, 16'h0, 1'b0, 4'b1000, 1'b1, 2'd3);
        applyStimulus(1'b0, 4'b1000, 4'b0000, 16'h1300, 2'b11, 1'b0);
        checkBeat("drop.b4", 1'b0, 16'h0, 1'b0, 4'b1000, 1'b1, 2'd3);
        applyStimulus(1'b1, 4'b1000, 4'b1000, 16'h1400, 2'b11, 1'b0);
        checkBeat("drop.b5", 1'b0, 16'h0, 1'b0, 4'b1000, 1'b1, 2'd3);
        checkOutput("drop.cnt_before", 32'(o_drop_cnt), 32'd0);
        applyStimulus(1'b1, 4'b0000, 4'b0000, 16'h0000, 2'b11, 1'b1);
        checkBeat("drop.done", 1'b0, 16'h0, 1'b0, 4'b0000, 1'b0, 2'd3);
        checkOutput("drop.cnt_after", 32'(o_drop_cnt), 32'd1);

        // Backpressure toggling during a 4-beat frame from requester 2; requester 0 waits.
        applyStimulus(1'b1, 4'b0100, 4'b0000, 16'hE000, 2'b11, 1'b1);
        checkBeat("bp.idle", 1'b0, 16'h0, 1'b0, 4'b0000, 1'b0, 2'd3);
        applyStimulus(1'b1, 4'b0101, 4'b0000, 16'hE000, 2'b11, 1'b1);
        checkBeat("bp.c1", 1'b1, 16'hE002, 1'b0, 4'b0100, 1'b1, 2'd2);
        if (o_m_tvalid && i_m_tready) nHs++;
        applyStimulus(1'b1, 4'b0101, 4'b0000, 16'hE100, 2'b11, 1'b0);
        checkBeat("bp.c2", 1'b1, 16'hE102, 1'b0, 4'b0000, 1'b1, 2'd2);
        if (o_m_tvalid && i_m_tready) nHs++;
        applyStimulus(1'b1, 4'b0101, 4'b0000, 16'hE100, 2'b11, 1'b1);
        checkBeat("bp.c3", 1'b1, 16'hE102, 1'b0, 4'b0100, 1'b1, 2'd2);
        if (o_m_tvalid && i_m_tready) nHs++;
        applyStimulus(1'b1, 4'b0101, 4'b0000, 16'hE200, 2'b11, 1'b0);
        checkBeat("bp.c4", 1'b1, 16'hE202, 1'b0, 4'b0000, 1'b1, 2'd2);
        if (o_m_tvalid && i_m_tready) nHs++;
        applyStimulus(1'b1, 4'b0101, 4'b0000, 16'hE200, 2'b11, 1'b1);
        checkBeat("bp.c5", 1'b1, 16'hE202, 1'b0, 4'b0100, 1'b1, 2'd2);
        if (o_m_tvalid && i_m_tready) nHs++;
        applyStimulus(1'b1, 4'b0101, 4'b0100, 16'hE300, 2'b01, 1'b0);
        checkBeat("bp.c6", 1'b1, 16'hE302, 1'b1, 4'b0000, 1'b1, 2'd2);
        checkOutput("bp.c6.keep", 32'(o_m_tkeep), 32'h1);
        if (o_m_tvalid && i_m_tready) nHs++;
        applyStimulus(1'b1, 4'b0101, 4'b0100, 16'hE300, 2'b01, 1'b1);
        checkBeat("bp.c7", 1'b1, 16'hE302, 1'b1, 4'b0100, 1'b1, 2'd2);
        if (o_m_tvalid && i_m_tready) nHs++;
        checkOutput("bp.handshakes", 32'(nHs), 32'd4);
        applyStimulus(1'b1, 4'b0000, 4'b0000, 16'h0000, 2'b11, 1'b1);
        checkBeat("bp.done", 1'b0, 16'h0, 1'b0, 4'b0000, 1'b0, 2'd2);

        // Tlast handshake coinciding with channel loss completes normally.
        applyStimulus(1'b1, 4'b0010, 4'b0010, 16'hF000, 2'b11, 1'b1);
        checkBeat("coin.idle", 1'b0, 16'h0, 1'b0, 4'b0000, 1'b0, 2'd2);
        applyStimulus(1'b0, 4'b0010, 4'b0010, 16'hF000, 2'b11, 1'b1);
        checkBeat("coin.last", 1'b1, 16'hF001, 1'b1, 4'b0010, 1'b1, 2'd1);
        applyStimulus(1'b0, 4'b0000, 4'b0000, 16'h0000, 2'b11, 1'b1);
        checkBeat("coin.done", 1'b0, 16'h0, 1'b0, 4'b0000, 1'b0, 2'd1);
        checkOutput("coin.drop_cnt", 32'(o_drop_cnt), 32'd1);

        // Mid-frame bubble keeps the grant.
        applyStimulus(1'b1, 4'b0001, 4'b0000, 16'h7000, 2'b11, 1'b1);
        checkBeat("bub.idle", 1'b0, 16'h0, 1'b0, 4'b0000, 1'b0, 2'd1);
        applyStimulus(1'b1, 4'b0001, 4'b0000, 16'h7000, 2'b11, 1'b1);
        checkBeat("bub.b1", 1'b1, 16'h7000, 1'b0, 4'b0001, 1'b1, 2'd0);
        applyStimulus(1'b1, 4'b0000, 4'b0000, 16'h7100, 2'b11, 1'b1);
        checkBeat("bub.gap", 1'b0, 16'h0, 1'b0, 4'b0001, 1'b1, 2'd0);
        applyStimulus(1'b1, 4'b0001, 4'b0001, 16'h7100, 2'b11, 1'b1);
        checkBeat("bub.b2", 1'b1, 16'h7100, 1'b1, 4'b0001, 1'b1, 2'd0);

        // Reset asserted mid-frame, then requester 0 wins after release.
        applyStimulus(1'b1, 4'b1111, 4'b0000, 16'hC000, 2'b11, 1'b1);
        checkBeat("rst.idle", 1'b0, 16'h0, 1'b0, 4'b0000, 1'b0, 2'd0);
        applyStimulus(1'b1, 4'b1111, 4'b0000, 16'hC000, 2'b11, 1'b1);
        checkBeat("rst.b1", 1'b1, 16'hC001, 1'b0, 4'b0010, 1'b1, 2'd1);
        i_reset = 1'b1;
        #1;
        checkBeat("rst.async", 1'b0, 16'h0, 1'b0, 4'b0000, 1'b0, 2'd0);
        checkOutput("rst.drop_cnt", 32'(o_drop_cnt), 32'd0);
        @(posedge clk);
        #1;
        i_reset = 1'b0;
        applyStimulus(1'b1, 4'b1111, 4'b1111, 16'hD000, 2'b11, 1'b1);
        checkBeat("rst.first", 1'b1, 16'hD000, 1'b1, 4'b0001, 1'b1, 2'd0);
        applyStimulus(1'b1, 4'b0000, 4'b0000, 16'h0000, 2'b11, 1'b1);
        checkBeat("rst.done", 1'b0, 16'h0, 1'b0, 4'b0000, 1'b0, 2'd0);

        $display("%0d/%0d checks passed", nPassed, nChecks);
        $finish;
    end

endmodule

// File: doc/aurora_tx_arbiter.md
Name: aurora_tx_arbiter

Overview:
Frame-granular round-robin arbiter that shares one Aurora 16-bit AXI4-Stream TX user interface between NUM_SRC requesters. It sits between the local data sources and the Aurora core TX port, and runs in the Aurora user-clock domain. It gates all traffic on CHANNEL_UP. If the channel drops mid-frame, it flushes the remainder of the in-flight frame so that no requester stalls.

Parameters:
NUM_SRC, 4, number of requesters (2..8)
IDX_W, 2, width of grant index; must equal clog2(NUM_SRC)
DATA_W, 16, stream data width; fixed at 16 to match the Aurora lane
KEEP_W, 2, DATA_W/8

Ports:
USER_CLK  in  1  Aurora user clock; sole clock
RESET  in  1  asynchronous, active-high reset
CHANNEL_UP  in  1  Aurora channel status, synchronous to USER_CLK
S_TDATA  in  NUM_SRC*DATA_W  requester data; slice i = bits [i*16 +: 16]
S_TVALID  in  NUM_SRC  per-requester valid
S_TKEEP  in  NUM_SRC*KEEP_W  per-requester keep
S_TLAST  in  NUM_SRC  per-requester end of frame
S_TREADY  out  NUM_SRC  per-requester ready
M_TDATA  out  DATA_W  to Aurora TX data
M_TVALID  out  1  to Aurora TX valid
M_TKEEP  out  KEEP_W  to Aurora TX keep
M_TLAST  out  1  to Aurora TX last
M_TREADY  in  1  from Aurora TX ready
GRANT_VALID  out  1  high while in SEND or FLUSH
GRANT_IDX  out  IDX_W  currently granted requester
DROP_CNT  out  16  count of frames aborted by channel loss; saturating

Behaviour:
- Reset state:
  - State = IDLE, GRANT_IDX = 0, GRANT_VALID = 0, DROP_CNT = 0.
  - last_grant = NUM_SRC-1, so requester 0 has first priority.
  - M_TVALID = 0 and S_TREADY = 0 while in reset.
- States: IDLE, SEND, FLUSH. The state register and grant index are the only registers on the data path; the data mux is combinational, so data latency is 0 cycles once granted.
- IDLE:
  - M_TVALID = 0, all S_TREADY = 0.
  - If CHANNEL_UP = 1 and any S_TVALID = 1: register GRANT_IDX = first asserted requester searching from last_grant+1 upward with wrap; next state = SEND.
  - Arbitration costs exactly 1 cycle, so the first beat appears on M_* in the cycle after the request is seen.
- SEND:
  - M_TDATA/M_TKEEP/M_TLAST/M_TVALID = slice GRANT_IDX of S_*.
  - S_TREADY[GRANT_IDX] = M_TREADY; all other S_TREADY = 0.
  - On a handshake (M_TVALID & M_TREADY & M_TLAST): last_grant <= GRANT_IDX, next state = IDLE. There is no back-to-back re-grant; one idle cycle separates frames.
  - If CHANNEL_UP = 0 in a cycle with no tlast handshake: next state = FLUSH, and M_TVALID is forced 0 in that same cycle.
  - If a tlast handshake and CHANNEL_UP falling coincide, the frame counts as complete: go to IDLE, no drop counted.
- FLUSH:
  - M_TVALID = 0; S_TREADY[GRANT_IDX] = 1 unconditionally; beats are discarded.
  - On S_TVALID[GRANT_IDX] & S_TLAST[GRANT_IDX]: DROP_CNT += 1, saturating at 16'hFFFF; last_grant <= GRANT_IDX; next state = IDLE.
  - CHANNEL_UP returning during FLUSH does not end FLUSH.
- A requester deasserting S_TVALID mid-frame (bubble) keeps the grant; M_TVALID follows it.
- RESET asserted mid-frame: immediate return to the reset state. The partial frame is not completed and not counted.
- The block assumes requesters hold TVALID/TDATA stable until ready, per AXI-Stream; this is not checked.

Optional Feature:
Macro AURORA_TX_ARB_WDOG_EN.
- Defined:
  - Adds a 16-bit stall counter in SEND that increments each cycle M_TVALID = 0 and clears on any handshake.
  - When it reaches 16'hFFFF, the arbiter enters FLUSH exactly as for channel loss and increments DROP_CNT.
  - Adds output WDOG_TRIP (1 bit), a one-cycle pulse on the trip; reset value 0.
- Undefined: no counter, no WDOG_TRIP port; a stalled requester holds the grant indefinitely.

Decomposition:
- Shared package aurora_tx_arb_pkg: state enum (IDLE=2'd0, SEND=2'd1, FLUSH=2'd2), DATA_W/KEEP_W constants, DROP_CNT width.
- One sub-module, rr_pick: a combinational round-robin priority picker taking the request vector and last_grant, returning next index and a found flag. It is reusable for the RX-side demux.

Test Plan:
- Idle, CHANNEL_UP = 1: requester 0 sends a 2-beat frame (16'hCAFE, then 16'hBABE with tlast, tkeep 2'b11), M_TREADY = 1 -> M_TDATA shows CAFE, then BABE, starting 1 cycle after request; GRANT_IDX = 0; back to IDLE.
- Requesters 0, 1, 2 all valid with 1-beat frames, repeated -> grant order 0,1,2,0,1,2; each frame separated by 1 idle cycle.
- CHANNEL_UP = 0, requester 1 valid -> no grant, M_TVALID = 0, S_TREADY = 0. Raise CHANNEL_UP -> grant to 1 on the next cycle.
- CHANNEL_UP drops after beat 2 of a 5-beat frame from requester 3 -> M_TVALID = 0 from that cycle; remaining 3 beats accepted with S_TREADY[3] = 1; DROP_CNT goes 0 -> 1.
- M_TREADY toggling 1,0,1,0 during a 4-beat frame -> exactly 4 handshakes, data order preserved, S_TREADY mirrors M_TREADY for the granted source only.
- RESET asserted mid-frame -> M_TVALID = 0 and GRANT_VALID = 0 asynchronously. After release, requester 0 wins if all request.
